// File: rtl/fwd_hazard_unit.sv
`timescale 1ns/1ps
// fwd_hazard_unit: shadow tag pipeline that drives EX operand forwarding selects and the ID load-use stall.
// Defining FWD_HAZARD_PERF_EN adds saturating stall/forward event counters.
module fwd_hazard_unit #(
    parameter int AW         = 5,
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    localparam int SW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze_i,
    input  logic                  flush_i,
    input  logic                  id_valid_i,
    input  logic [NUM_SRC*AW-1:0] id_rs_i,
    input  logic [AW-1:0]         id_rd_i,
    input  logic                  id_regwrite_i,
    input  logic                  id_load_i,
    output logic                  stall_o,
    output logic [NUM_SRC*SW-1:0] fwd_sel_o
`ifdef FWD_HAZARD_PERF_EN
    ,
    output logic [31:0]           stall_cnt_o,
    output logic [31:0]           fwd_cnt_o
`endif
);

    logic [DEPTH-1:0] tag_v;
    logic [DEPTH-1:0] tag_we;
    logic [DEPTH-1:0] tag_ld;
    logic [AW-1:0]    tag_rd [DEPTH];
    logic [AW-1:0]    ex_rs  [NUM_SRC];
    logic [AW-1:0]    id_rs  [NUM_SRC];
    logic             id_we;
    logic             load_hit;
    logic             issue;

    always_comb begin
        for (int j = 0; j < NUM_SRC; j++) begin
            id_rs[j] = id_rs_i[j*AW +: AW];
        end
    end

    // x0 is never a producer, so a write to it is captured as a non-writer.
    assign id_we = id_regwrite_i & (id_rd_i != '0);

    always_comb begin
        load_hit = 1'b0;
        for (int j = 0; j < NUM_SRC; j++) begin
            for (int k = 0; k < LOAD_STAGE - 1; k++) begin
                if (tag_v[k] && tag_we[k] && tag_ld[k] &&
                    tag_rd[k] == id_rs[j] && id_rs[j] != '0) begin
                    load_hit = 1'b1;
                end
            end
        end
    end

    assign stall_o = id_valid_i & ~flush_i & ~freeze_i & load_hit;
    assign issue   = id_valid_i & ~stall_o & ~flush_i;

    // Oldest stage first so the youngest matching producer overwrites it; a
    // load whose data is not ready yet forces the register-file path.
    always_comb begin
        fwd_sel_o = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                if (tag_v[k] && tag_we[k] && tag_rd[k] == ex_rs[j] && ex_rs[j] != '0) begin
                    fwd_sel_o[j*SW +: SW] = (tag_ld[k] && k < LOAD_STAGE) ? '0 : SW'(k);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v  <= '0;
            tag_we <= '0;
            tag_ld <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                tag_rd[k] <= '0;
            end
            for (int j = 0; j < NUM_SRC; j++) begin
                ex_rs[j] <= '0;
            end
        end else if (!freeze_i) begin
            tag_v  <= {tag_v[DEPTH-2:0], issue};
            tag_we <= {tag_we[DEPTH-2:0], issue & id_we};
            tag_ld <= {tag_ld[DEPTH-2:0], issue & id_load_i};
            for (int k = 1; k < DEPTH; k++) begin
                tag_rd[k] <= tag_rd[k-1];
            end
            tag_rd[0] <= issue ? id_rd_i : '0;
            for (int j = 0; j < NUM_SRC; j++) begin
                ex_rs[j] <= issue ? id_rs[j] : '0;
            end
        end
    end

`ifdef FWD_HAZARD_PERF_EN
    logic fwd_any;

    assign fwd_any = |fwd_sel_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_o <= '0;
            fwd_cnt_o   <= '0;
        end else if (!freeze_i) begin
            if (stall_o && stall_cnt_o != '1) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
            if (fwd_any && fwd_cnt_o != '1) begin
                fwd_cnt_o <= fwd_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
`timescale 1ns/1ps
// Table-driven bench for fwd_hazard_unit: per-cycle ID stimulus with hand-derived
// expected stall/select values queued on drive and compared mid-cycle.
module tb_fwd_hazard_unit;

    localparam int AW      = 5;
    localparam int NUM_SRC = 2;
    localparam int DEPTH   = 3;
    localparam int SW      = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  freeze_i;
    logic                  flush_i;
    logic                  id_valid_i;
    logic [NUM_SRC*AW-1:0] id_rs_i;
    logic [AW-1:0]         id_rd_i;
    logic                  id_regwrite_i;
    logic                  id_load_i;
    logic                  stall_o;
    logic [NUM_SRC*SW-1:0] fwd_sel_o;
`ifdef FWD_HAZARD_PERF_EN
    logic [31:0]           stall_cnt_o;
    logic [31:0]           fwd_cnt_o;
`endif

    always #5 clk = ~clk;

    fwd_hazard_unit #(
        .AW         (AW),
        .NUM_SRC    (NUM_SRC),
        .DEPTH      (DEPTH),
        .LOAD_STAGE (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .freeze_i      (freeze_i),
        .flush_i       (flush_i),
        .id_valid_i    (id_valid_i),
        .id_rs_i       (id_rs_i),
        .id_rd_i       (id_rd_i),
        .id_regwrite_i (id_regwrite_i),
        .id_load_i     (id_load_i),
        .stall_o       (stall_o),
        .fwd_sel_o     (fwd_sel_o)
`ifdef FWD_HAZARD_PERF_EN
        ,
        .stall_cnt_o   (stall_cnt_o),
        .fwd_cnt_o     (fwd_cnt_o)
`endif
    );

    typedef struct {
        logic          rst;
        logic          frz;
        logic          fl;
        logic          v;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic [AW-1:0] rd;
        logic          we;
        logic          ld;
        logic          st;
        logic [SW-1:0] s0;
        logic [SW-1:0] s1;
    } vec_t;

    typedef struct {
        logic          st;
        logic [SW-1:0] s0;
        logic [SW-1:0] s1;
        int            row;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic vec_t mk(input int r, input int f, input int fl, input int v,
                                input int rs1, input int rs2, input int rd,
                                input int we, input int ld,
                                input int st, input int s0, input int s1);
        vec_t t;
        t.rst = 1'(r);
        t.frz = 1'(f);
        t.fl  = 1'(fl);
        t.v   = 1'(v);
        t.rs1 = 5'(rs1);
        t.rs2 = 5'(rs2);
        t.rd  = 5'(rd);
        t.we  = 1'(we);
        t.ld  = 1'(ld);
        t.st  = 1'(st);
        t.s0  = 2'(s0);
        t.s1  = 2'(s1);
        return t;
    endfunction

    task automatic check(input string name, input int row, input logic [31:0] act,
                         input logic [31:0] expv);
        n_checks++;
        if (act === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s row %0d: got %0d, expected %0d", name, row, act, expv);
        end
    endtask

    task automatic drive(input vec_t t);
        rst           = t.rst;
        freeze_i      = t.frz;
        flush_i       = t.fl;
        id_valid_i    = t.v;
        id_rs_i       = {t.rs2, t.rs1};
        id_rd_i       = t.rd;
        id_regwrite_i = t.we;
        id_load_i     = t.ld;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);

        //            rst frz fl v  rs1 rs2 rd we ld  st s0 s1
        vecs.push_back(mk(0, 0, 0, 0,  0,  0,  0, 0, 0,  0, 0, 0));  // 0 reset state
        vecs.push_back(mk(0, 0, 0, 1,  1,  2,  5, 1, 0,  0, 0, 0));  // add x5
        vecs.push_back(mk(0, 0, 0, 1,  5,  2,  6, 1, 0,  0, 0, 0));  // sub rs1=x5
        vecs.push_back(mk(0, 0, 0, 0,  0,  0,  0, 0, 0,  0, 1, 0));  // sub in EX
        vecs.push_back(mk(0, 0, 0, 0,  0,  0,  0, 0, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  0,  0,  7, 1, 0,  0, 0, 0));  // 5 addi x7
        vecs.push_back(mk(0, 0, 0, 1,  0,  0,  7, 1, 0,  0, 0, 0));  // addi x7
        vecs.push_back(mk(0, 0, 0, 1,  7,  7,  8, 1, 0,  0, 0, 0));  // or x7,x7
        vecs.push_back(mk(0, 0, 0, 0,  0,  0,  0, 0, 0,  0, 1, 1));  // youngest wins
        vecs.push_back(mk(0, 0, 0, 0,  0,  0,  0, 0, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  0,  0,  7, 1, 0,  0, 0, 0));  // 10 addi x7
        vecs.push_back(mk(0, 0, 0, 1,  0,  0,  9, 0, 0,  0, 0, 0));  // non-writer
        vecs.push_back(mk(0, 0, 0, 1,  7,  7,  8, 1, 0,  0, 0, 0));  // or x7,x7
        vecs.push_back(mk(0, 0, 0, 0,  0,  0,  0, 0, 0,  0, 2, 2));
        vecs.push_back(mk(0, 0, 0, 0,  0,  0,  0, 0, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  1,  0,  3, 1, 1,  0, 0, 0));  // 15 lw x3
        vecs.push_back(mk(0, 0, 0, 1,  4,  3, 10, 1, 0,  1, 0, 0));  // add rs2=x3 stalls
        vecs.push_back(mk(0, 0, 0, 1,  4,  3, 10, 1, 0,  0, 0, 0));  // bubble in EX
        vecs.push_back(mk(0, 0, 0, 0,  0,  0,  0, 0, 0,  0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0,  0,  0,  0, 0, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  0,  0,  0, 1, 0,  0, 0, 0));  // 20 addi x0
        vecs.push_back(mk(0, 0, 0, 1,  0,  2, 11, 1, 0,  0, 0, 0));  // add rs1=x0
        vecs.push_back(mk(0, 0, 0, 0,  0,  0,  0, 0, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  1,  2,  4, 0, 0,  0, 0, 0));  // sw, rd field 4
        vecs.push_back(mk(0, 0, 0, 1,  4,  0, 12, 1, 0,  0, 0, 0));  // add rs1=x4
        vecs.push_back(mk(0, 0, 0, 0,  0,  0,  0, 0, 0,  0, 0, 0));  // 25
        vecs.push_back(mk(0, 0, 0, 1,  1,  0,  3, 1, 1,  0, 0, 0));  // lw x3
        vecs.push_back(mk(0, 0, 1, 1,  3,  0,  3, 1, 0,  0, 0, 0));  // flushed add x3
        vecs.push_back(mk(0, 0, 0, 1,  3,  3, 13, 1, 0,  0, 0, 0));  // add x13,x3,x3
        vecs.push_back(mk(0, 1, 0, 1, 13,  0, 14, 1, 0,  0, 2, 2));  // freeze x3
        vecs.push_back(mk(0, 1, 0, 1, 13,  0, 14, 1, 0,  0, 2, 2));  // 30
        vecs.push_back(mk(0, 1, 0, 1, 13,  0, 14, 1, 0,  0, 2, 2));
        vecs.push_back(mk(0, 0, 0, 1, 13,  0, 14, 1, 0,  0, 2, 2));
        vecs.push_back(mk(0, 0, 0, 0,  0,  0,  0, 0, 0,  0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0,  0,  0,  0, 0, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  1,  0,  6, 1, 1,  0, 0, 0));  // 35 lw x6
        vecs.push_back(mk(0, 1, 0, 1,  6,  0, 15, 1, 0,  0, 0, 0));  // frozen use
        vecs.push_back(mk(0, 0, 0, 1,  6,  0, 15, 1, 0,  1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  6,  0, 15, 1, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,  0,  0,  0, 0, 0,  0, 2, 0));
        vecs.push_back(mk(0, 0, 0, 0,  0,  0,  0, 0, 0,  0, 0, 0));  // 40
        vecs.push_back(mk(0, 0, 0, 1,  0,  0,  9, 1, 0,  0, 0, 0));  // addi x9
        vecs.push_back(mk(0, 0, 0, 1,  9,  0,  3, 1, 1,  0, 0, 0));  // lw x3,(x9)
        vecs.push_back(mk(1, 0, 0, 1,  3,  0, 16, 1, 0,  1, 1, 0));  // reset mid-stall
        vecs.push_back(mk(0, 0, 0, 1,  3,  0, 16, 1, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,  0,  0,  0, 0, 0,  0, 0, 0));  // 45 load gone
        vecs.push_back(mk(0, 0, 0, 1,  0,  0, 20, 1, 0,  0, 0, 0));  // addi x20
        vecs.push_back(mk(0, 0, 0, 1,  0,  0, 21, 1, 0,  0, 0, 0));  // addi x21
        vecs.push_back(mk(0, 0, 0, 1, 21, 20, 22, 1, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,  0,  0,  0, 0, 0,  0, 1, 2));  // mixed stages
        vecs.push_back(mk(0, 0, 0, 0,  0,  0,  0, 0, 0,  0, 0, 0));  // 50
        vecs.push_back(mk(0, 0, 0, 1,  0,  0,  4, 1, 1,  0, 0, 0));  // lw x4
        vecs.push_back(mk(0, 0, 0, 0,  0,  0,  0, 0, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  0,  4, 17, 1, 0,  0, 0, 0));  // distance 2, no stall
        vecs.push_back(mk(0, 0, 0, 0,  0,  0,  0, 0, 0,  0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0,  0,  0,  0, 0, 0,  0, 0, 0));  // 55
        vecs.push_back(mk(0, 0, 0, 1,  0,  0,  5, 1, 1,  0, 0, 0));  // lw x5
        vecs.push_back(mk(0, 0, 0, 0,  5,  0, 18, 1, 0,  0, 0, 0));  // invalid ID: no stall
        vecs.push_back(mk(0, 0, 0, 0,  0,  0,  0, 0, 0,  0, 0, 0));

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            sb.push_back('{st: vecs[i].st, s0: vecs[i].s0, s1: vecs[i].s1, row: i});
            @(negedge clk);
            e = sb.pop_front();
            check("stall", e.row, 32'(stall_o), 32'(e.st));
            check("sel0", e.row, 32'(fwd_sel_o[SW-1:0]), 32'(e.s0));
            check("sel1", e.row, 32'(fwd_sel_o[2*SW-1:SW]), 32'(e.s1));
        end

`ifdef FWD_HAZARD_PERF_EN
        @(posedge clk); #1;
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        drive(mk(0, 0, 0, 1, 0, 0, 3, 1, 1, 0, 0, 0));   // lw x3
        @(negedge clk);
        check("stall_cnt_rst", 0, stall_cnt_o, 32'd0);
        check("fwd_cnt_rst", 0, fwd_cnt_o, 32'd0);
        @(posedge clk); #1;
        drive(mk(0, 0, 0, 1, 3, 0, 19, 1, 0, 0, 0, 0));  // dependent add
        @(negedge clk);
        check("perf_stall", 0, 32'(stall_o), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        @(negedge clk);
        check("stall_cnt", 1, stall_cnt_o, 32'd1);
        check("fwd_cnt", 1, fwd_cnt_o, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the combinational EX-stage forwarding unit.
- Tracks destination tags of in-flight instructions in an internal shadow pipeline (EX, MEM, WB, …).
- Generates per-operand forwarding selects for the EX stage, plus the load-use stall/bubble for ID.
- Sits beside the ID/EX pipeline registers. It replaces externally supplied RD/RegWrite/s_or_b wiring with its own tag pipeline.

Parameters:
- AW, 5, register address width.
- NUM_SRC, 2, source operands per instruction.
- DEPTH, 3, tracked stages (0=EX … DEPTH-1). Must be ≥2.
- LOAD_STAGE, 2, first stage index whose result can be forwarded for a load. Must satisfy 1 ≤ LOAD_STAGE ≤ DEPTH-1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- freeze_i  in  1  global pipeline hold; no state changes.
- flush_i  in  1  kill the ID instruction; a bubble enters EX.
- id_valid_i  in  1  the ID stage holds a real instruction.
- id_rs_i  in  NUM_SRC*AW  ID source register addresses; operand j is in bits [j*AW +: AW].
- id_rd_i  in  AW  ID destination register.
- id_regwrite_i  in  1  ID instruction writes rd. This is 0 for S/B types.
- id_load_i  in  1  ID instruction is a load.
- stall_o  out  1  hold PC and IF/ID, and insert a bubble into EX.
- fwd_sel_o  out  NUM_SRC*SW  EX operand selects, with SW = $clog2(DEPTH). Operand j is in bits [j*SW +: SW].

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high, on rst.
- Per-stage tag: {v, we, ld, rd}. Also held: ex_rs[NUM_SRC] for the instruction currently in EX.
- Reset state:
  - All tags are 0 and all ex_rs are 0.
  - Outputs: stall_o=0, fwd_sel_o=0.
- Tag capture: we is stored as id_regwrite_i & (id_rd_i != 0). A write to x0 is never a producer.
- Load-use stall (combinational from ID inputs and tags): stall_o=1 iff all of the following hold:
  - id_valid_i=1, flush_i=0, freeze_i=0;
  - some operand j and some stage k with 0 ≤ k ≤ LOAD_STAGE-2 have tag[k].v & we & ld, and tag[k].rd == id_rs[j];
  - id_rs[j] != 0.
- Default LOAD_STAGE=2: only a load sitting in EX stalls, for exactly 1 cycle.
- Advance, on a clock edge with freeze_i=0:
  - tag[k] ← tag[k-1] for k = 1..DEPTH-1.
  - If id_valid_i & ~stall_o & ~flush_i: tag[0] ← {1, we, id_load_i, id_rd_i} and ex_rs ← id_rs_i.
  - Otherwise (bubble): tag[0] ← 0 and ex_rs ← 0.
- Freeze: with freeze_i=1, all state holds. stall_o=0 and fwd_sel_o are recomputed from the held state.
- Priority: rst > freeze_i > flush_i > stall.
  - Flush and stall in the same cycle → flush wins; stall_o=0.
  - Reset mid-stall clears everything the next cycle.
- Forwarding select (combinational from registered state, 0-cycle latency), for each operand j:
  - fwd_sel[j] = smallest k in 1..DEPTH-1 with tag[k].v & we, tag[k].rd == ex_rs[j], and ex_rs[j] != 0.
  - If there is no match, fwd_sel[j] = 0 (register file).
  - Youngest producer wins when several stages match.
  - A load in stage k < LOAD_STAGE is never selected. The stall guarantees this cannot occur; if the stall is bypassed, the select falls back to 0.
- Encoding: 0 = register file, k = result of stage k (DEPTH=3: 1=MEM, 2=WB). This differs from the old 2'b10/2'b01 encoding; the EX operand mux is updated to match.
- Both source operands may select the same or different stages independently.

Optional Feature:
- Macro: FWD_HAZARD_PERF_EN.
- When defined:
  - Adds outputs stall_cnt_o [31:0] and fwd_cnt_o [31:0].
  - stall_cnt_o increments on every cycle with stall_o=1 and freeze_i=0.
  - fwd_cnt_o increments on every non-frozen cycle where any fwd_sel[j] != 0.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0 on rst.
- When undefined: the ports and counters are absent, and the rest of the behaviour is identical.

Test Plan:
- EX→EX dependency:
  - Stimulus: issue `add x5` (regwrite), then `sub` with rs1=x5, no freeze.
  - Required: in the cycle `sub` is in EX, fwd_sel[0]=1, fwd_sel[1]=0, stall_o=0.
- Double producer:
  - Stimulus: `addi x7`, then `addi x7`, then `or` with rs1=x7, rs2=x7.
  - Required: fwd_sel = {1,1} (youngest producer). With one intervening non-writer instead of the second `addi`, fwd_sel = {2,2}.
- Load-use:
  - Stimulus: `lw x3`, then `add` with rs2=x3.
  - Required: stall_o=1 for exactly 1 cycle and tag[0].v=0 (bubble). When `add` then reaches EX, fwd_sel[1]=2.
- x0 and S/B:
  - Stimulus: `addi x0`, then `add` with rs1=x0; separately, `sw` (id_regwrite_i=0) with rd field 4, then `add` with rs1=x4.
  - Required: fwd_sel=0 in both cases, and no stall.
- Flush/freeze:
  - Stimulus: `lw x3` followed by `add` rs1=x3 with flush_i=1 in the same cycle.
  - Required: stall_o=0 and a bubble enters EX. Then freeze_i=1 for 3 cycles holds the fwd_sel value unchanged, and stall_o=0 throughout.
- Reset:
  - Stimulus: assert rst during a load-use stall.
  - Required: the next cycle shows stall_o=0 and fwd_sel_o=0. With FWD_HAZARD_PERF_EN defined, both counters read 0 after reset and stall_cnt_o=1 after a single load-use event.
